// File: rtl/node_mac_seq_if.sv
// Activation-in / result-out stream bundle for the neuron node.
// No storage of its own; it only groups the two valid/ready channels.
// The slave side is the node; the master side is whoever feeds it and drains it.
interface node_mac_seq_if #(
   parameter int DW = 8
) ();
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/node_mac_seq.sv
// Time-multiplexed neuron: N_IN beats x loadable weights, + bias, ReLU, rescale, saturate.
// Latency: last beat accepted at edge E, result valid from just after E+1; frame >= N_IN+2 cycles.
// Backpressure: in_ready low in FIN/OUT; result held in OUT until out_ready. NODE_MAC_ROUND_EN selects round-half-up.
module node_mac_seq #(
   parameter int N_IN = 15,
   parameter int DW   = 8,
   parameter int WW   = 8,
   parameter int FRAC = 6,
   parameter int ACCW = DW + WW + $clog2(N_IN) + 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    w_we,
   input  logic [$clog2(N_IN)-1:0] w_addr,
   input  logic signed [WW-1:0]    w_data,
   input  logic                    b_we,
   input  logic signed [DW+WW-1:0] b_data,
   input  logic                    frame_clr,
   node_mac_seq_if.slave           s_if
);

   localparam int                     CW     = $clog2(N_IN);
   localparam int                     PW     = DW + WW;
   localparam logic [CW-1:0]          LAST   = CW'(N_IN - 1);
   localparam logic [CW:0]            N_IN_W = (CW + 1)'(N_IN);
   localparam logic signed [ACCW-1:0] QMAX   = ACCW'((1 << (DW - 1)) - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN, S_OUT} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [DW-1:0]          out_q, out_d;
   logic signed [WW-1:0]   w_q [N_IN];
   logic signed [PW-1:0]   bias_q;

   logic                   in_rdy;
   logic                   accept;
   logic signed [DW-1:0]   act_s;
   logic signed [WW-1:0]   w_sel;
   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] s_sum;
   logic signed [ACCW-1:0] q_sh;
   logic signed [ACCW-1:0] q_fin;
   logic [DW-1:0]          r_val;

   // in_ready is forced low while reset is asserted, not just after it.
   assign in_rdy = reset_n && ((state_q == S_IDLE) || (state_q == S_ACC));
   assign accept = s_if.in_valid && in_rdy;

   assign act_s = $signed(s_if.in_data);
   assign w_sel = w_q[cnt_q];
   assign prod  = PW'(act_s) * PW'(w_sel);

   assign s_sum = acc_q + ACCW'(bias_q);
   assign q_sh  = s_sum >>> FRAC;

`ifdef NODE_MAC_ROUND_EN
   // Round half up: add back the first discarded bit; a carry past QMAX saturates below.
   assign q_fin = q_sh + ACCW'(s_sum[FRAC-1]);
`else
   assign q_fin = q_sh;
`endif

   assign r_val = s_sum[ACCW-1] ? '0 :
                  (q_fin > QMAX) ? QMAX[DW-1:0] : q_fin[DW-1:0];

   assign s_if.in_ready  = in_rdy;
   assign s_if.out_valid = (state_q == S_OUT);
   assign s_if.out_data  = out_q;

   // Weight and bias storage; writes are honoured in every state and out-of-range indices dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
         bias_q <= '0;
      end else begin
         if (w_we && ({1'b0, w_addr} < N_IN_W)) w_q[w_addr] <= w_data;
         if (b_we) bias_q <= b_data;
      end
   end

   // FSM state, beat counter, accumulator and held result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   // Next-state logic: frame_clr aborts everything; otherwise accumulate, finish, then hold the result.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      out_d   = out_q;
      if (frame_clr) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         acc_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_ACC: begin
               if (accept) begin
                  acc_d = acc_q + ACCW'(prod);
                  if (cnt_q == LAST) begin
                     cnt_d   = '0;
                     state_d = S_FIN;
                  end else begin
                     cnt_d   = cnt_q + 1'b1;
                     state_d = S_ACC;
                  end
               end
            end
            S_FIN: begin
               out_d   = r_val;
               state_d = S_OUT;
            end
            S_OUT: begin
               if (s_if.out_ready) begin
                  state_d = S_IDLE;
                  acc_d   = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_node_mac_seq.sv
// Self-checking bench for node_mac_seq: directed cases plus randomized frames against a reference model.
// Checks reset values, exact result latency, stall holding, frame abort and asynchronous reset.
// Inputs are driven and outputs sampled just after the falling edge.
module tb_node_mac_seq;
   localparam int N_IN = 15;
   localparam int DW   = 8;
   localparam int WW   = 8;
   localparam int FRAC = 6;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        w_we;
   logic [3:0]  w_addr;
   logic [7:0]  w_data;
   logic        b_we;
   logic [15:0] b_data;
   logic        frame_clr;

   node_mac_seq_if #(.DW(DW)) bus ();

   node_mac_seq #(.N_IN(N_IN), .DW(DW), .WW(WW), .FRAC(FRAC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .w_we      (w_we),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .b_we      (b_we),
      .b_data    (b_data),
      .frame_clr (frame_clr),
      .s_if      (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int wm [N_IN];
   int bm;
   int fa [N_IN];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic wr_w(input int a, input int d);
      w_we   = 1'b1;
      w_addr = 4'(a);
      w_data = 8'(d);
      step();
      w_we = 1'b0;
      if (a < N_IN) wm[a] = d;
   endtask

   task automatic wr_b(input int d);
      b_we   = 1'b1;
      b_data = 16'(d);
      step();
      b_we = 1'b0;
      bm   = d;
   endtask

   task automatic load_all(input int d);
      for (int i = 0; i < N_IN; i++) wr_w(i, d);
   endtask

   // Reference: plain integer dot product + bias, ReLU, shift, optional rounding, clamp.
   function automatic int model();
      longint s;
      longint q;
      s = bm;
      for (int i = 0; i < N_IN; i++) s += longint'(fa[i]) * longint'(wm[i]);
      if (s < 0) return 0;
      q = s / (64'sd1 << FRAC);
`ifdef NODE_MAC_ROUND_EN
      if ((s % (64'sd1 << FRAC)) >= (64'sd1 << (FRAC - 1))) q = q + 1;
`endif
      if (q > 127) q = 127;
      return int'(q);
   endfunction

   task automatic send_beats(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(fa[i]);
         step();
      end
      bus.in_valid = 1'b0;
   endtask

   // Full frame with optional input gaps and output stall; checks latency and holding.
   task automatic run_frame(input int gap_pct, input int stall);
      int exp;
      exp = model();
      bus.out_ready = (stall == 0);
      for (int i = 0; i < N_IN; i++) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            step();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(fa[i]);
         chk("in_ready_beat", int'(bus.in_ready), 1);
         step();
      end
      bus.in_valid = 1'b0;
      chk("out_valid_fin", int'(bus.out_valid), 0);
      chk("in_ready_fin", int'(bus.in_ready), 0);
      step();
      chk("out_valid_e1", int'(bus.out_valid), 1);
      chk("out_data", int'(bus.out_data), exp);
      for (int k = 0; k < stall; k++) begin
         step();
         chk("stall_valid", int'(bus.out_valid), 1);
         chk("stall_data", int'(bus.out_data), exp);
         chk("stall_in_ready", int'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("out_valid_done", int'(bus.out_valid), 0);
      chk("out_data_kept", int'(bus.out_data), exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset_n       = 1'b0;
      w_we          = 1'b0;
      w_addr        = '0;
      w_data        = '0;
      b_we          = 1'b0;
      b_data        = '0;
      frame_clr     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < N_IN; i++) wm[i] = 0;
      bm = 0;

      #1;
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("idle_in_ready", int'(bus.in_ready), 1);
      chk("idle_out_valid", int'(bus.out_valid), 0);

      // All weights 1, beats 64
      load_all(1);
      for (int i = 0; i < N_IN; i++) fa[i] = 64;
      run_frame(0, 0);

      // Single product at the rounding boundary
      load_all(0);
      wr_w(0, 32);
      for (int i = 0; i < N_IN; i++) fa[i] = 0;
      fa[0] = 1;
      run_frame(0, 0);

      // Saturation, then ReLU
      load_all(31);
      for (int i = 0; i < N_IN; i++) fa[i] = 127;
      run_frame(0, 0);
      load_all(-1);
      for (int i = 0; i < N_IN; i++) fa[i] = 64;
      run_frame(0, 0);

      // Bias only, with a 5-cycle output stall
      wr_b(6400);
      for (int i = 0; i < N_IN; i++) fa[i] = 0;
      run_frame(0, 5);
      wr_b(0);

      // Same frame gap-free and with input gaps
      for (int i = 0; i < N_IN; i++) begin
         wr_w(i, int'($urandom_range(0, 24)) - 12);
         fa[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_frame(0, 0);
      run_frame(50, 0);

      // Abort after 8 beats; the dropped beat and partial sum must not leak
      send_beats(8);
      frame_clr    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd100;
      step();
      frame_clr    = 1'b0;
      bus.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("clr_out_valid", int'(bus.out_valid), 0);
         chk("clr_in_ready", int'(bus.in_ready), 1);
         step();
      end
      run_frame(0, 0);

      // Out-of-range weight index is ignored
      wr_w(15, 77);
      run_frame(0, 0);

      // Randomized frames
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < N_IN; i++) begin
            wr_w(i, int'($urandom_range(0, 40)) - 20);
            fa[i] = int'($urandom_range(0, 255)) - 128;
         end
         wr_b(int'($urandom_range(0, 8000)) - 4000);
         run_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
      end
      wr_b(0);

      // Asynchronous reset mid-frame clears everything including weights
      load_all(1);
      for (int i = 0; i < N_IN; i++) fa[i] = 64;
      run_frame(0, 0);
      send_beats(5);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", int'(bus.out_valid), 0);
      chk("arst_in_ready", int'(bus.in_ready), 0);
      chk("arst_out_data", int'(bus.out_data), 0);
      for (int i = 0; i < N_IN; i++) wm[i] = 0;
      bm = 0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      for (int i = 0; i < N_IN; i++) fa[i] = 127;
      run_frame(0, 0);
      load_all(1);
      for (int i = 0; i < N_IN; i++) fa[i] = 64;
      run_frame(0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
